rv32_writeback_unit: RTL and testbench



---
 rtl/rv32_writeback_unit.sv | 122 ++++++++++++
 tb/tb_rv32_writeback_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rv32_writeback_unit.sv
// rv32_writeback_unit
//
// Write-side master of the 32x32 register file. ALU and load results arrive
// on two valid/ready channels and are merged into the single register-file
// write port. A busy scoreboard tracks destination registers that still have
// a result in flight, so decode can stall on RAW hazards.
//
// Handshake: a channel transfers a beat on a rising edge where valid and
// ready are both high. Once valid is raised, the producer holds valid, rd and
// data stable until that transfer happens. Ready is computed from the other
// channel's valid and the starvation counter only. It never looks at the
// write port, which has no backpressure.
//
// Ports
//   clk, reset              core clock; synchronous active-high reset
//   alu_valid/ready/rd/data ALU result channel
//   ld_valid/ready/rd/data  load result channel
//   issue_valid, issue_rd   decode issued an instruction that writes issue_rd
//   busy_mask               bit i set = register i has a pending write (bit 0 = 0)
//   rf_write, rf_rw, rf_d   register-file write port, posedge registered
//                           (the register file samples on the falling edge)
//
// STARVE_LIMIT (legal 1..15): the maximum number of consecutive load grants
// while the ALU is waiting. After that many, the ALU gets the next grant.

module rv32_writeback_unit #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] busy_mask,
  output logic        rf_write,
  output logic [4:0]  rf_rw,
  output logic [31:0] rf_d
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        starved;
  logic        alu_acc;
  logic        ld_acc;
  logic        acc_any;
  logic [4:0]  acc_rd;
  logic [31:0] acc_data;
  logic [31:0] busy_q;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] busy_next;

  // Load wins by default because it is the longer-latency producer. Once the
  // ALU has lost STARVE_LIMIT times in a row, the priority flips for one
  // beat. The two readies are mutually exclusive whenever both are valid.
  assign starved   = (starve_cnt == LIMIT);
  assign alu_ready = !ld_valid || starved;
  assign ld_ready  = !(alu_valid && starved);

  assign alu_acc = alu_valid && alu_ready;
  assign ld_acc  = ld_valid && ld_ready;
  assign acc_any = alu_acc || ld_acc;

  always_comb begin
    acc_rd   = ld_rd;
    acc_data = ld_data;
    if (alu_acc) begin
      acc_rd   = alu_rd;
      acc_data = alu_data;
    end
  end

  // Scoreboard update. A set applied after the clear makes a newly issued
  // producer win over a retiring one that targets the same register.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (acc_any && (acc_rd != 5'd0)) clr_mask[acc_rd] = 1'b1;
    if (issue_valid && (issue_rd != 5'd0)) set_mask[issue_rd] = 1'b1;
    busy_next    = (busy_q & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  assign busy_mask = {busy_q[31:1], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      busy_q     <= '0;
      rf_write   <= 1'b0;
      rf_rw      <= '0;
      rf_d       <= '0;
    end else begin
      // The count only means something while the ALU is waiting. Any ALU
      // grant, or any cycle with no ALU result offered, starts it over.
      if (!alu_valid || alu_acc) begin
        starve_cnt <= '0;
      end else if (ld_acc && !starved) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      busy_q <= busy_next;

      // A result for x0 still completes its handshake but does not write.
      // rf_rw and rf_d keep their last values when nothing is accepted.
      rf_write <= acc_any && (acc_rd != 5'd0);
      if (acc_any) begin
        rf_rw <= acc_rd;
        rf_d  <= acc_data;
      end
    end
  end

endmodule

// File: tb/tb_rv32_writeback_unit.sv
module tb_rv32_writeback_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, ld_valid, issue_valid;
  logic        alu_ready, ld_ready;
  logic [4:0]  alu_rd, ld_rd, issue_rd;
  logic [31:0] alu_data, ld_data;
  logic [31:0] busy_mask;
  logic        rf_write;
  logic [4:0]  rf_rw;
  logic [31:0] rf_d;

  always #5 clk = ~clk;

  rv32_writeback_unit #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy_mask(busy_mask),
    .rf_write(rf_write), .rf_rw(rf_rw), .rf_d(rf_d)
  );

  // ---------------- scoreboard ----------------
  logic [36:0] exp_q[$];   // {rw, d}
  int n_vec  = 0;
  int n_miss = 0;
  int a_k    = 0;          // next ALU beat index
  int l_k    = 0;          // next load beat index

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_write === 1'b1) begin
      logic [36:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_write: got rw=%0d d=%h, none expected at %0t", rf_rw, rf_d, $time);
      end else begin
        e = exp_q.pop_front();
        if ({rf_rw, rf_d} !== e) begin
          n_miss++;
          $display("FAIL write_port: got rw=%0d d=%h expected rw=%0d d=%h at %0t",
                   rf_rw, rf_d, e[36:32], e[31:0], $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Both channels valid for n cycles. Bit i of alu_pat is the hand-derived
  // grant for cycle i (1 = ALU, 0 = load). Each channel offers its next beat
  // until that beat is accepted.
  task automatic both_valid(input int n, input logic [15:0] alu_pat);
    for (int i = 0; i < n; i++) begin
      alu_valid = 1'b1;
      ld_valid  = 1'b1;
      alu_rd    = 5'd10;
      alu_data  = 32'hA000_0000 | 32'(a_k);
      ld_rd     = 5'd11;
      ld_data   = 32'hB000_0000 | 32'(l_k);
      @(negedge clk);
      if (i > 0) chk("back_to_back_write", {31'd0, rf_write}, 32'd1);
      chk("alu_ready_arb", {31'd0, alu_ready}, {31'd0, alu_pat[i]});
      chk("ld_ready_arb", {31'd0, ld_ready}, {31'd0, !alu_pat[i]});
      if (alu_pat[i]) exp_q.push_back({5'd10, 32'hA000_0000 | 32'(a_k)});
      else            exp_q.push_back({5'd11, 32'hB000_0000 | 32'(l_k)});
      next_cycle();
      if (alu_pat[i]) a_k++;
      else            l_k++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state, then the first ALU result after reset.
    @(negedge clk);
    chk("reset_rf_write", {31'd0, rf_write}, 32'd0);
    chk("reset_rf_rw", {27'd0, rf_rw}, 32'd0);
    chk("reset_rf_d", rf_d, 32'd0);
    chk("reset_busy", busy_mask, 32'd0);
    chk("first_alu_ready", {31'd0, alu_ready}, 32'd1);
    exp_q.push_back({5'd5, 32'h0000_1234});
    next_cycle();
    alu_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("write_one_cycle", {31'd0, rf_write}, 32'd0);
    next_cycle();

    // Issue x7, then retire it through the load channel.
    issue_valid = 1'b1; issue_rd = 5'd7;
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("busy_set_x7", busy_mask, 32'h0000_0080);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hDEAD_BEEF;
    exp_q.push_back({5'd7, 32'hDEAD_BEEF});
    next_cycle();
    ld_valid = 1'b0;
    @(negedge clk);
    chk("busy_clr_x7", busy_mask, 32'd0);
    next_cycle();

    // Contention for 10 cycles: L,L,L,L,A,L,L,L,L,A.
    both_valid(10, 16'b0000_0010_0001_0000);
    alu_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("last_contended_write", {31'd0, rf_write}, 32'd1);
    next_cycle();

    // x0 result and x0 issue: handshake completes, nothing written or marked.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    @(negedge clk);
    chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
    next_cycle();
    alu_valid = 1'b0; issue_valid = 1'b0;
    @(negedge clk);
    chk("x0_no_write", {31'd0, rf_write}, 32'd0);
    chk("x0_busy", busy_mask, 32'd0);
    next_cycle();

    // x3 re-issued on the same edge its previous result retires.
    issue_valid = 1'b1; issue_rd = 5'd3;
    next_cycle();
    @(negedge clk);
    chk("busy_set_x3", busy_mask, 32'h0000_0008);
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h3333_3333;
    exp_q.push_back({5'd3, 32'h3333_3333});
    next_cycle();
    issue_valid = 1'b0;
    ld_data = 32'h3333_4444;
    @(negedge clk);
    chk("set_wins_x3", busy_mask, 32'h0000_0008);
    exp_q.push_back({5'd3, 32'h3333_4444});
    next_cycle();
    ld_valid = 1'b0;
    @(negedge clk);
    chk("busy_clr_x3", busy_mask, 32'd0);
    next_cycle();

    // Build up starvation, issue x12, then reset right after a load accept.
    issue_valid = 1'b1; issue_rd = 5'd12;
    both_valid(3, 16'b0);
    issue_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("busy_before_reset_edge", busy_mask, 32'h0000_1000);
    next_cycle();
    @(negedge clk);
    chk("mid_reset_rf_write", {31'd0, rf_write}, 32'd0);
    chk("mid_reset_busy", busy_mask, 32'd0);
    next_cycle();
    reset = 1'b0;
    // Counter must restart from 0: four load grants before the ALU's turn.
    both_valid(5, 16'b0000_0000_0001_0000);
    alu_valid = 1'b0; ld_valid = 1'b0;
    repeat (3) next_cycle();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
